axistream_swap_arbiter: RTL and testbench
=========================================

AXISTREAM_SWAP_ARBITER -- requirements
Module: axistream_swap_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, tdata width of every stream.
REQ-002 Parameter ROUTE_DEPTH, default 4, power of two >= 2, in-flight packet route entries.
REQ-003 Parameter TIMEOUT, default 256, watchdog stall limit in cycles.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s0_tvalid/tready/tdata/tlast  in/out/in/in  1/1/DATA_WIDTH/1  requester 0 source stream.
REQ-007 s1_tvalid/tready/tdata/tlast  in/out/in/in  1/1/DATA_WIDTH/1  requester 1 source stream.
REQ-008 m_tvalid/tready/tdata/tlast  out/in/out/out  1/1/DATA_WIDTH/1  stream into the shared compare-swap stage.
REQ-009 r_tvalid/tready/tdata/tlast  in/out/in/in  1/1/DATA_WIDTH/1  stream returning from the compare-swap stage.
REQ-010 d0_tvalid/tready/tdata/tlast  out/in/out/out  1/1/DATA_WIDTH/1  requester 0 result stream.
REQ-011 d1_tvalid/tready/tdata/tlast  out/in/out/out  1/1/DATA_WIDTH/1  requester 1 result stream.
REQ-012 wd_err  output  1  sticky watchdog error.

Function
REQ-013 Arbiter FSM SHALL have states IDLE, GRANT0, GRANT1; arbitration is packet-granular.
REQ-014 IDLE: if route FIFO not full and any sX_tvalid, grant round-robin (requester other than last_grant wins ties; lone requester wins); transition next cycle.
REQ-015 IDLE: all sX_tready=0, m_tvalid=0.
REQ-016 GRANTx: m_tvalid/tdata/tlast = sx_*, sx_tready = m_tready, non-granted sY_tready=0; zero added latency.
REQ-017 GRANTx: beat accepted with tlast=1 -> IDLE next cycle, last_grant<=x.
REQ-018 IDLE->GRANTx transition SHALL push id x into route FIFO same edge.
REQ-019 Route FIFO empty: r_tready=0, d0_tvalid=d1_tvalid=0.
REQ-020 Route FIFO non-empty with head h: dh_* = r_* combinationally, r_tready = dh_tready, other dY_tvalid=0.
REQ-021 Accepted r beat with r_tlast=1 SHALL pop route FIFO same edge.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged; full FIFO SHALL hold FSM in IDLE.
REQ-023 Packet order per requester and across the shared stage SHALL be preserved; data never modified.

Reset
REQ-024 rst_n low SHALL immediately force: FSM IDLE, last_grant=1 (requester 0 first), route FIFO empty, watchdog count 0, wd_err 0.
REQ-025 During reset all tvalid and tready outputs SHALL be 0; reset mid-packet drops the packet with no recovery.

Configuration
REQ-026 Macro AXISTREAM_SWAP_ARB_WATCHDOG_EN defined: counter increments each GRANTx cycle with sx_tvalid=0, clears on any accepted m beat or in IDLE; reaching TIMEOUT sets wd_err, cleared only by reset.
REQ-027 Macro undefined: no counter logic, wd_err tied 0, port retained.

Structure
REQ-028 Shared package axistream_swap_pkg SHALL hold FSM state encodings, requester-id width (1), and the ROUTE_DEPTH pointer-width function.
REQ-029 Route FIFO SHALL be sub-module axistream_route_fifo (synchronous, 1-bit data, full/empty flags, same async active-low reset).

Verification
REQ-030 s0 sends 3-beat packet {5,9,2} alone -> m beats 5,9,2, tlast on 2; r returns {9,5,2} -> appears on d0 only, FIFO empty after.
REQ-031 s0 and s1 both valid out of reset -> s0 packet granted first, s1 next; repeated contention alternates 0,1,0,1.
REQ-032 r_tready held low, ROUTE_DEPTH=4 single-beat packets pushed -> 5th packet not granted until one r tlast accepted.
REQ-033 d1_tready=0 with head id 1 -> r_tready=0, d0_tvalid=0 throughout stall; data unchanged when released.
REQ-034 Macro defined, TIMEOUT=8, s1 granted and drops tvalid mid-packet 8 cycles -> wd_err=1 and stays 1 until rst_n low.
REQ-035 rst_n asserted mid-packet in GRANT0 -> all tvalid/tready 0 immediately, after release s0 first priority, FIFO empty.

Source files
------------

// File: rtl/axistream_swap_pkg.sv
// Shared types for the compare-swap arbiter: FSM encodings, requester id, pointer width.
// Latency: n/a (types only).
// Backpressure: n/a.
package axistream_swap_pkg;

    localparam int ID_W = 1;

    typedef logic [ID_W-1:0] req_id_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_e;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/axistream_route_fifo.sv
// Route FIFO holding the requester id of every packet in flight through the shared stage.
// Latency: push visible at head one cycle later; pop frees the slot the same edge.
// Backpressure: push ignored when full, pop ignored when empty; full/empty flags exported.
module axistream_route_fifo
    import axistream_swap_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push_vld,
    input  req_id_t push_dat,
    input  logic    pop_vld,
    output req_id_t head_dat,
    output logic    full,
    output logic    empty
);

    localparam int PW = ptr_width(DEPTH);

    req_id_t        mem_q [DEPTH];
    req_id_t        mem_d [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW:0]    cnt_q, cnt_d;
    logic           do_push, do_pop;

    assign full     = (cnt_q == (PW+1)'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign head_dat = mem_q[rd_ptr_q];
    assign do_push  = push_vld && !full;
    assign do_pop   = pop_vld && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Power-of-two depth lets the pointers wrap without compare logic.
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/axistream_swap_arbiter.sv
// Packet-granular round-robin arbiter sharing one compare-swap stage between two requesters;
// zero added latency on both the forward and return paths; route FIFO full stalls new grants,
// return path follows head-of-route destination tready. Optional watchdog: AXISTREAM_SWAP_ARB_WATCHDOG_EN.
module axistream_swap_arbiter
    import axistream_swap_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ROUTE_DEPTH = 4,
    parameter int TIMEOUT     = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s0_tvalid,
    output logic                  s0_tready,
    input  logic [DATA_WIDTH-1:0] s0_tdata,
    input  logic                  s0_tlast,
    input  logic                  s1_tvalid,
    output logic                  s1_tready,
    input  logic [DATA_WIDTH-1:0] s1_tdata,
    input  logic                  s1_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tlast,
    input  logic                  r_tvalid,
    output logic                  r_tready,
    input  logic [DATA_WIDTH-1:0] r_tdata,
    input  logic                  r_tlast,
    output logic                  d0_tvalid,
    input  logic                  d0_tready,
    output logic [DATA_WIDTH-1:0] d0_tdata,
    output logic                  d0_tlast,
    output logic                  d1_tvalid,
    input  logic                  d1_tready,
    output logic [DATA_WIDTH-1:0] d1_tdata,
    output logic                  d1_tlast,
    output logic                  wd_err
);

    arb_state_e state_q, state_d;
    req_id_t    last_grant_q, last_grant_d;
    logic       push_vld;
    req_id_t    push_dat;
    logic       pop_vld;
    req_id_t    head_dat;
    logic       fifo_full, fifo_empty;

    axistream_route_fifo #(
        .DEPTH (ROUTE_DEPTH)
    ) u_route_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        push_vld     = 1'b0;
        push_dat     = '0;
        s0_tready    = 1'b0;
        s1_tready    = 1'b0;
        m_tvalid     = 1'b0;
        m_tdata      = '0;
        m_tlast      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_full && (s0_tvalid || s1_tvalid)) begin
                    push_vld = 1'b1;
                    // Tie goes to whoever did not win last time.
                    if (s0_tvalid && s1_tvalid) begin
                        push_dat = ~last_grant_q;
                    end else begin
                        push_dat = s1_tvalid ? 1'b1 : 1'b0;
                    end
                    state_d = (push_dat == 1'b1) ? ST_GRANT1 : ST_GRANT0;
                end
            end
            ST_GRANT0: begin
                m_tvalid  = s0_tvalid;
                m_tdata   = s0_tdata;
                m_tlast   = s0_tlast;
                s0_tready = m_tready;
                if (s0_tvalid && m_tready && s0_tlast) begin
                    state_d      = ST_IDLE;
                    last_grant_d = 1'b0;
                end
            end
            ST_GRANT1: begin
                m_tvalid  = s1_tvalid;
                m_tdata   = s1_tdata;
                m_tlast   = s1_tlast;
                s1_tready = m_tready;
                if (s1_tvalid && m_tready && s1_tlast) begin
                    state_d      = ST_IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        r_tready  = 1'b0;
        d0_tvalid = 1'b0;
        d1_tvalid = 1'b0;
        d0_tdata  = r_tdata;
        d0_tlast  = r_tlast;
        d1_tdata  = r_tdata;
        d1_tlast  = r_tlast;
        if (!fifo_empty) begin
            if (head_dat == 1'b0) begin
                d0_tvalid = r_tvalid;
                r_tready  = d0_tready;
            end else begin
                d1_tvalid = r_tvalid;
                r_tready  = d1_tready;
            end
        end
    end

    assign pop_vld = r_tvalid && r_tready && r_tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef AXISTREAM_SWAP_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_err_q, wd_err_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == ST_IDLE || (m_tvalid && m_tready)) begin
            wd_cnt_d = '0;
        end else if (((state_q == ST_GRANT0) && !s0_tvalid) ||
                     ((state_q == ST_GRANT1) && !s1_tvalid)) begin
            if (wd_cnt_q != WD_W'(TIMEOUT)) begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
        wd_err_d = wd_err_q || (wd_cnt_d == WD_W'(TIMEOUT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign wd_err = wd_err_q;
`else
    assign wd_err = 1'b0;
`endif

endmodule

// File: tb/tb_axistream_swap_arbiter.sv
// Directed bench for axistream_swap_arbiter: queue-driven sources, scoreboarded m/d0/d1 outputs.
module tb_axistream_swap_arbiter;

    localparam int DW = 8;
    localparam int RD = 4;
    localparam int TO = 8;
`ifdef AXISTREAM_SWAP_ARB_WATCHDOG_EN
    localparam logic WD_EXP = 1'b1;
`else
    localparam logic WD_EXP = 1'b0;
`endif

    typedef logic [DW:0] beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s0_tvalid, s0_tready, s0_tlast;
    logic [DW-1:0] s0_tdata;
    logic          s1_tvalid, s1_tready, s1_tlast;
    logic [DW-1:0] s1_tdata;
    logic          m_tvalid, m_tready, m_tlast;
    logic [DW-1:0] m_tdata;
    logic          r_tvalid, r_tready, r_tlast;
    logic [DW-1:0] r_tdata;
    logic          d0_tvalid, d0_tready, d0_tlast;
    logic [DW-1:0] d0_tdata;
    logic          d1_tvalid, d1_tready, d1_tlast;
    logic [DW-1:0] d1_tdata;
    logic          wd_err;

    beat_t src0_q[$], src1_q[$], r_q[$];
    beat_t m_exp[$], d0_exp[$], d1_exp[$];
    int    total = 0;
    int    bad   = 0;
    bit    s0_acc, s1_acc, r_acc;

    always #5 clk = ~clk;

    axistream_swap_arbiter #(
        .DATA_WIDTH  (DW),
        .ROUTE_DEPTH (RD),
        .TIMEOUT     (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s0_tvalid (s0_tvalid),
        .s0_tready (s0_tready),
        .s0_tdata  (s0_tdata),
        .s0_tlast  (s0_tlast),
        .s1_tvalid (s1_tvalid),
        .s1_tready (s1_tready),
        .s1_tdata  (s1_tdata),
        .s1_tlast  (s1_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .r_tvalid  (r_tvalid),
        .r_tready  (r_tready),
        .r_tdata   (r_tdata),
        .r_tlast   (r_tlast),
        .d0_tvalid (d0_tvalid),
        .d0_tready (d0_tready),
        .d0_tdata  (d0_tdata),
        .d0_tlast  (d0_tlast),
        .d1_tvalid (d1_tvalid),
        .d1_tready (d1_tready),
        .d1_tdata  (d1_tdata),
        .d1_tlast  (d1_tlast),
        .wd_err    (wd_err)
    );

    function automatic beat_t mk(input logic last, input int data);
        return {last, data[DW-1:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic unexpected(input string tag, input logic [31:0] got);
        total++;
        bad++;
        $error("FAIL %s observed=%0h expected=no beat", tag, got);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_m(input string tag);
        int done = 0;
        for (int i = 0; i < 300 && done == 0; i++) begin
            step(1);
            if (m_exp.size() == 0) done = 1;
        end
        chk(tag, done, 1);
    endtask

    task automatic wait_all(input string tag);
        int done = 0;
        for (int i = 0; i < 300 && done == 0; i++) begin
            step(1);
            if (src0_q.size() == 0 && src1_q.size() == 0 && r_q.size() == 0 &&
                m_exp.size() == 0 && d0_exp.size() == 0 && d1_exp.size() == 0) done = 1;
        end
        chk(tag, done, 1);
    endtask

    // Output monitors and handshake capture, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            s0_acc = rst_n && s0_tvalid && s0_tready;
            s1_acc = rst_n && s1_tvalid && s1_tready;
            r_acc  = rst_n && r_tvalid && r_tready;
            if (rst_n && m_tvalid && m_tready) begin
                if (m_exp.size() == 0) unexpected("m_beat", {m_tlast, m_tdata});
                else chk("m_beat", {m_tlast, m_tdata}, m_exp.pop_front());
            end
            if (rst_n && d0_tvalid && d0_tready) begin
                if (d0_exp.size() == 0) unexpected("d0_beat", {d0_tlast, d0_tdata});
                else chk("d0_beat", {d0_tlast, d0_tdata}, d0_exp.pop_front());
            end
            if (rst_n && d1_tvalid && d1_tready) begin
                if (d1_exp.size() == 0) unexpected("d1_beat", {d1_tlast, d1_tdata});
                else chk("d1_beat", {d1_tlast, d1_tdata}, d1_exp.pop_front());
            end
        end
    end

    // Source drivers: present the queue head, pop after an accepted beat.
    initial begin
        s0_tvalid = 1'b0; s0_tdata = '0; s0_tlast = 1'b0;
        s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0;
        r_tvalid  = 1'b0; r_tdata  = '0; r_tlast  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (s0_acc && src0_q.size() > 0) void'(src0_q.pop_front());
            if (s1_acc && src1_q.size() > 0) void'(src1_q.pop_front());
            if (r_acc && r_q.size() > 0) void'(r_q.pop_front());
            s0_tvalid = (src0_q.size() > 0);
            if (src0_q.size() > 0) {s0_tlast, s0_tdata} = src0_q[0];
            s1_tvalid = (src1_q.size() > 0);
            if (src1_q.size() > 0) {s1_tlast, s1_tdata} = src1_q[0];
            r_tvalid = (r_q.size() > 0);
            if (r_q.size() > 0) {r_tlast, r_tdata} = r_q[0];
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        rst_n     = 1'b0;
        m_tready  = 1'b1;
        d0_tready = 1'b1;
        d1_tready = 1'b1;

        // Reset state
        step(2);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_s0_tready", s0_tready, 0);
        chk("rst_s1_tready", s1_tready, 0);
        chk("rst_r_tready", r_tready, 0);
        chk("rst_d0_tvalid", d0_tvalid, 0);
        chk("rst_d1_tvalid", d1_tvalid, 0);
        chk("rst_wd_err", wd_err, 0);
        rst_n = 1'b1;
        step(1);

        // Contention out of reset: s0 first, then alternating
        src0_q.push_back(mk(0, 10)); src0_q.push_back(mk(1, 11));
        src0_q.push_back(mk(0, 12)); src0_q.push_back(mk(1, 13));
        src1_q.push_back(mk(0, 20)); src1_q.push_back(mk(1, 21));
        src1_q.push_back(mk(0, 22)); src1_q.push_back(mk(1, 23));
        m_exp.push_back(mk(0, 10)); m_exp.push_back(mk(1, 11));
        m_exp.push_back(mk(0, 20)); m_exp.push_back(mk(1, 21));
        m_exp.push_back(mk(0, 12)); m_exp.push_back(mk(1, 13));
        m_exp.push_back(mk(0, 22)); m_exp.push_back(mk(1, 23));
        r_q.push_back(mk(0, 11)); r_q.push_back(mk(1, 10));
        r_q.push_back(mk(0, 21)); r_q.push_back(mk(1, 20));
        r_q.push_back(mk(0, 13)); r_q.push_back(mk(1, 12));
        r_q.push_back(mk(0, 23)); r_q.push_back(mk(1, 22));
        d0_exp.push_back(mk(0, 11)); d0_exp.push_back(mk(1, 10));
        d0_exp.push_back(mk(0, 13)); d0_exp.push_back(mk(1, 12));
        d1_exp.push_back(mk(0, 21)); d1_exp.push_back(mk(1, 20));
        d1_exp.push_back(mk(0, 23)); d1_exp.push_back(mk(1, 22));
        wait_all("drain_contention");

        // Lone s0 packet {5,9,2}, swapped return {9,5,2} to d0 only
        src0_q.push_back(mk(0, 5)); src0_q.push_back(mk(0, 9)); src0_q.push_back(mk(1, 2));
        m_exp.push_back(mk(0, 5)); m_exp.push_back(mk(0, 9)); m_exp.push_back(mk(1, 2));
        wait_m("drain_m_single");
        r_q.push_back(mk(0, 9)); r_q.push_back(mk(0, 5)); r_q.push_back(mk(1, 2));
        d0_exp.push_back(mk(0, 9)); d0_exp.push_back(mk(0, 5)); d0_exp.push_back(mk(1, 2));
        wait_all("drain_single");
        step(2);
        chk("single_fifo_empty_r_tready", r_tready, 0);

        // Route FIFO full: fifth packet held until a return tlast
        for (int i = 0; i < 5; i++) src0_q.push_back(mk(1, 30 + i));
        for (int i = 0; i < 4; i++) m_exp.push_back(mk(1, 30 + i));
        wait_m("drain_m_fill");
        step(10);
        chk("full_m_tvalid", m_tvalid, 0);
        chk("full_s0_tready", s0_tready, 0);
        m_exp.push_back(mk(1, 34));
        for (int i = 0; i < 5; i++) begin
            r_q.push_back(mk(1, 30 + i));
            d0_exp.push_back(mk(1, 30 + i));
        end
        wait_all("drain_full");

        // d1 backpressure with head id 1
        src1_q.push_back(mk(0, 40)); src1_q.push_back(mk(1, 41));
        m_exp.push_back(mk(0, 40)); m_exp.push_back(mk(1, 41));
        wait_m("drain_m_stall");
        d1_tready = 1'b0;
        r_q.push_back(mk(0, 41)); r_q.push_back(mk(1, 40));
        d1_exp.push_back(mk(0, 41)); d1_exp.push_back(mk(1, 40));
        step(5);
        chk("stall_r_tready", r_tready, 0);
        chk("stall_d0_tvalid", d0_tvalid, 0);
        chk("stall_d1_tvalid", d1_tvalid, 1);
        chk("stall_d1_tdata", d1_tdata, 41);
        step(3);
        chk("stall_d0_tvalid_late", d0_tvalid, 0);
        chk("stall_d1_tdata_late", d1_tdata, 41);
        d1_tready = 1'b1;
        wait_all("drain_stall");

        // s1 granted, tvalid dropped mid-packet for more than TIMEOUT cycles
        src1_q.push_back(mk(0, 50));
        m_exp.push_back(mk(0, 50));
        wait_m("drain_m_wd_first");
        step(12);
        chk("wd_err_set", wd_err, WD_EXP);
        src1_q.push_back(mk(0, 51)); src1_q.push_back(mk(1, 52));
        m_exp.push_back(mk(0, 51)); m_exp.push_back(mk(1, 52));
        wait_m("drain_m_wd_rest");
        chk("wd_err_sticky", wd_err, WD_EXP);
        r_q.push_back(mk(0, 50)); r_q.push_back(mk(0, 51)); r_q.push_back(mk(1, 52));
        d1_exp.push_back(mk(0, 50)); d1_exp.push_back(mk(0, 51)); d1_exp.push_back(mk(1, 52));
        wait_all("drain_wd");
        chk("wd_err_sticky_idle", wd_err, WD_EXP);

        // Reset mid-packet while GRANT0 is stalled by m_tready
        m_tready = 1'b0;
        src0_q.push_back(mk(0, 60)); src0_q.push_back(mk(0, 61)); src0_q.push_back(mk(1, 62));
        step(3);
        chk("pre_rst_m_tvalid", m_tvalid, 1);
        chk("pre_rst_m_tdata", m_tdata, 60);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_tvalid", m_tvalid, 0);
        chk("mid_rst_s0_tready", s0_tready, 0);
        chk("mid_rst_s1_tready", s1_tready, 0);
        chk("mid_rst_r_tready", r_tready, 0);
        chk("mid_rst_d0_tvalid", d0_tvalid, 0);
        chk("mid_rst_d1_tvalid", d1_tvalid, 0);
        chk("mid_rst_wd_err", wd_err, 0);
        src0_q.delete();
        step(2);
        rst_n = 1'b1;
        m_tready = 1'b1;
        step(1);
        chk("post_rst_fifo_empty", r_tready, 0);
        chk("post_rst_m_tvalid", m_tvalid, 0);
        src0_q.push_back(mk(1, 70));
        src1_q.push_back(mk(1, 80));
        m_exp.push_back(mk(1, 70)); m_exp.push_back(mk(1, 80));
        r_q.push_back(mk(1, 70)); r_q.push_back(mk(1, 80));
        d0_exp.push_back(mk(1, 70));
        d1_exp.push_back(mk(1, 80));
        wait_all("drain_post_rst");

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
